// File: rtl/key_debounce_pulse_if.sv
// Push-button conditioning bundle: raw key level in,
// debounced level plus press/release pulses out.
interface key_debounce_pulse_if;
  logic key_in;
  logic key_level;
  logic key_press;
  logic key_release;

  modport master (
    output key_in,
    input  key_level,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_in,
    output key_level,
    output key_press,
    output key_release
  );
endinterface

// File: rtl/key_debounce_pulse.sv
// Synchronises and debounces a push-button; emits one-cycle
// press/release pulses with optional auto-repeat while held.
module key_debounce_pulse #(
  parameter int ACTIVE_LOW    = 1,
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_RATE   = 8
) (
  input  logic clk,
  input  logic rst,
  key_debounce_pulse_if.slave kif
);
  localparam int MAX_A =
    (STABLE_CYCLES > REPEAT_DELAY) ? STABLE_CYCLES : REPEAT_DELAY;
  localparam int MAX_C =
    (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
  localparam int CW = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] STABLE   = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] DLY_END  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_END = CW'(REPEAT_RATE - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic          REL      = (ACTIVE_LOW != 0);
  localparam logic          RPT_ON   = (REPEAT_EN != 0);

  typedef enum logic [2:0] {
    IDLE,
    CHK_DN,
    HELD,
    RPT,
    CHK_UP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1_q, sync2_q;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          k;

  // Sync FFs idle at the released level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= REL;
      sync2_q   <= REL;
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= kif.key_in;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign k = sync2_q ^ REL;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (k) begin
          state_d = CHK_DN;
          cnt_d   = ONE;
        end
      end
      CHK_DN: begin
        if (!k) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == STABLE) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      HELD: begin
        if (!k) begin
          state_d = CHK_UP;
          cnt_d   = ONE;
        end else if (RPT_ON && cnt_q == DLY_END) begin
          state_d = RPT;
          cnt_d   = '0;
          press_d = 1'b1;
        end else if (cnt_q != DLY_END) begin
          cnt_d = cnt_q + ONE;
        end
      end
      RPT: begin
        if (!k) begin
          state_d = CHK_UP;
          cnt_d   = ONE;
        end else if (cnt_q == RATE_END) begin
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      CHK_UP: begin
        // A bounce back to pressed restarts the repeat delay.
        if (k) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == STABLE) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign kif.key_level   = (state_q == HELD) ||
                           (state_q == RPT)  ||
                           (state_q == CHK_UP);
  assign kif.key_press   = press_q;
  assign kif.key_release = release_q;
endmodule

// File: tb/tb_key_debounce_pulse.sv
// Scoreboard bench: two configurations share one button,
// a run-length model predicts pulses and debounced level.
module tb_key_debounce_pulse;
  localparam int NI  = 2;
  localparam int DLY = 16;
  localparam int RTE = 8;

  typedef struct packed {
    int at;
    bit rel;
  } ev_t;

  logic clk;
  logic rst;
  logic pr;

  int cfg_s [NI] = '{4, 3};
  bit cfg_rep [NI] = '{1'b0, 1'b1};

  key_debounce_pulse_if if0 ();
  key_debounce_pulse_if if1 ();

  assign if0.key_in = ~pr;
  assign if1.key_in = pr;

  key_debounce_pulse #(
    .ACTIVE_LOW(1), .STABLE_CYCLES(4), .REPEAT_EN(0),
    .REPEAT_DELAY(DLY), .REPEAT_RATE(RTE)
  ) dut0 (
    .clk(clk), .rst(rst), .kif(if0.slave)
  );

  key_debounce_pulse #(
    .ACTIVE_LOW(0), .STABLE_CYCLES(3), .REPEAT_EN(1),
    .REPEAT_DELAY(DLY), .REPEAT_RATE(RTE)
  ) dut1 (
    .clk(clk), .rst(rst), .kif(if1.slave)
  );

  logic lvl [NI];
  logic prs [NI];
  logic rls [NI];
  assign lvl[0] = if0.key_level;
  assign prs[0] = if0.key_press;
  assign rls[0] = if0.key_release;
  assign lvl[1] = if1.key_level;
  assign prs[1] = if1.key_press;
  assign rls[1] = if1.key_release;

  int errors = 0;
  int checks = 0;

  bit  m_s1, m_s2;
  int  edge_n;
  bit  m_lvl [NI];
  int  m_run [NI];
  int  m_t [NI];
  ev_t evq [NI][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a new level is accepted after STABLE+1 agreeing
  // synced samples; repeats fall DLY, DLY+RTE, ... edges
  // after the hold (re)started.
  task automatic model_step(input int i, input bit k);
    if (!m_lvl[i]) begin
      if (k) begin
        m_run[i]++;
        if (m_run[i] == cfg_s[i] + 1) begin
          m_lvl[i] = 1'b1;
          m_run[i] = 0;
          m_t[i]   = 0;
          evq[i].push_back('{at: edge_n, rel: 1'b0});
        end
      end else begin
        m_run[i] = 0;
      end
    end else if (!k) begin
      m_run[i]++;
      if (m_run[i] == cfg_s[i] + 1) begin
        m_lvl[i] = 1'b0;
        m_run[i] = 0;
        evq[i].push_back('{at: edge_n, rel: 1'b1});
      end
    end else if (m_run[i] > 0) begin
      m_run[i] = 0;
      m_t[i]   = 0;
    end else begin
      m_t[i]++;
      if (cfg_rep[i] && m_t[i] >= DLY &&
          (m_t[i] - DLY) % RTE == 0)
        evq[i].push_back('{at: edge_n, rel: 1'b0});
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_s1   = 1'b0;
        m_s2   = 1'b0;
        edge_n = 0;
        for (int i = 0; i < NI; i++) begin
          m_lvl[i] = 1'b0;
          m_run[i] = 0;
          m_t[i]   = 0;
        end
      end else begin
        bit k;
        k = m_s2;
        m_s2 = m_s1;
        m_s1 = pr;
        edge_n++;
        for (int i = 0; i < NI; i++)
          model_step(i, k);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (rst) begin
          evq[i].delete();
          checks++;
          if ({lvl[i], prs[i], rls[i]} !== 3'b000) begin
            errors++;
            $display("FAIL reset_out inst%0d: got %b want 000",
                     i, {lvl[i], prs[i], rls[i]});
          end
        end else begin
          while (evq[i].size() > 0 && evq[i][0].at < edge_n) begin
            checks++;
            errors++;
            $display("FAIL missed_pulse inst%0d edge %0d: got none want rel=%0b",
                     i, evq[i][0].at, evq[i][0].rel);
            void'(evq[i].pop_front());
          end
          if (prs[i] && rls[i]) begin
            checks++;
            errors++;
            $display("FAIL both_pulses inst%0d edge %0d: got 11 want not both",
                     i, edge_n);
          end
          if (prs[i] || rls[i]) begin
            checks++;
            if (evq[i].size() == 0 || evq[i][0].at != edge_n) begin
              errors++;
              $display("FAIL extra_pulse inst%0d edge %0d: got press=%0b rel=%0b want none",
                       i, edge_n, prs[i], rls[i]);
            end else begin
              ev_t e;
              e = evq[i].pop_front();
              if (rls[i] !== e.rel) begin
                errors++;
                $display("FAIL pulse_kind inst%0d edge %0d: got rel=%0b want rel=%0b",
                         i, edge_n, rls[i], e.rel);
              end
            end
          end
          checks++;
          if (lvl[i] !== m_lvl[i]) begin
            errors++;
            $display("FAIL key_level inst%0d edge %0d: got %0b want %0b",
                     i, edge_n, lvl[i], m_lvl[i]);
          end
        end
      end
    end
  end

  task automatic hold(input bit v, input int n);
    @(posedge clk);
    #2 pr = v;
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    rst = 1'b0;
    pr  = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    hold(1'b1, 20);
    hold(1'b0, 20);

    for (int j = 0; j < 10; j++)
      hold(j % 2 == 0, 1);
    hold(1'b0, 15);

    hold(1'b1, 70);
    hold(1'b0, 2);
    hold(1'b1, 40);

    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    hold(1'b1, 25);
    hold(1'b0, 20);

    repeat (40)
      hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
    hold(1'b0, 20);

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (evq[i].size() != 0) begin
        errors++;
        $display("FAIL pending_events inst%0d: got %0d left want 0",
                 i, evq[i].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
